// File: rtl/legv8_pkg.sv
// Shared defaults and state encoding for the LEGv8 pipelined register file.
package legv8_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_DEF = 31;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/legv8_scoreboard.sv
// Per-register busy scoreboard: decode claims set, writeback clears, claim wins on a tie.
module legv8_scoreboard
  import legv8_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0]                busy_q;
  logic [DEPTH-1:0]                busy_d;
  logic [NUM_RD-1:0][ADDR_W-1:0]   ra;
  logic [NUM_RD-1:0]               rd_busy_p1;

  assign ra = rd_addr;

  // Write clears first, then claim sets, so a same-address claim leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (enable) begin
      if (wr_en && (wr_addr != ZERO_ADDR))
        busy_d[wr_addr] = 1'b0;
      if (claim_en && (claim_addr != ZERO_ADDR))
        busy_d[claim_addr] = 1'b1;
    end
  end

  // Stage p1: scoreboard state and post-update busy lookups.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q     <= '0;
      rd_busy_p1 <= '0;
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NUM_RD; i++)
        rd_busy_p1[i] <= enable && (ra[i] != ZERO_ADDR) && busy_d[ra[i]];
    end
  end

  assign rd_busy  = rd_busy_p1;
  assign busy_vec = busy_q;

endmodule

// File: rtl/legv8_regfile_sb.sv
// LEGv8 register file: N registered read ports, one write port, write-first bypass,
// hardwired zero register, post-reset clear sequencer and busy scoreboard.
module legv8_regfile_sb
  import legv8_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  rf_state_e                     state_q;
  rf_state_e                     state_d;
  logic [ADDR_W-1:0]             clr_ptr_q;
  logic [DATA_W-1:0]             mem [DEPTH];
  logic [NUM_RD-1:0][ADDR_W-1:0] ra;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data_p1;
  logic                          wr_fire;

  assign ready   = (state_q == RUN);
  assign ra      = rd_addr;
  assign wr_fire = ready && wr_en && (wr_addr != ZERO_ADDR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_ptr_q == LAST_PTR) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR)
        clr_ptr_q <= clr_ptr_q + PTR_ONE;
    end
  end

  // Storage has no reset; the clear sequencer zeroes one entry per cycle instead.
  always_ff @(posedge clock) begin
    if (state_q == CLEAR)
      mem[clr_ptr_q] <= '0;
    else if (!reset && wr_fire)
      mem[wr_addr] <= wr_data;
  end

  // Stage p1: registered read data with write-first bypass.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (reset || !ready)
        rd_data_p1[i] <= '0;
      else if (ra[i] == ZERO_ADDR)
        rd_data_p1[i] <= '0;
      else if (wr_fire && (wr_addr == ra[i]))
        rd_data_p1[i] <= wr_data;
      else
        rd_data_p1[i] <= mem[ra[i]];
    end
  end

  assign rd_data = rd_data_p1;

  legv8_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .enable     (ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy),
    .busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_legv8_regfile_sb.sv
// Directed and randomized bench for legv8_regfile_sb against an array-based reference model.
module tb_legv8_regfile_sb;

  logic         clock = 1'b0;
  logic         reset;
  logic         ready;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         claim_en;
  logic [4:0]   claim_addr;
  logic [31:0]  busy_vec;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_mem [32];
  bit          m_busy [32];
  bit          m_run = 1'b0;
  int          m_cnt = 0;

  legv8_regfile_sb dut (
    .clock      (clock),
    .reset      (reset),
    .ready      (ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy_vec   (busy_vec)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model across one edge, clock the DUT, then compare every output.
  task automatic tick(input string tag);
    logic [63:0] e_rd [2];
    logic        e_bz [2];
    logic [31:0] e_vec;
    bit          run_pre;
    int          a;
    run_pre = m_run;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  = 64'd0;
        m_busy[r] = 1'b0;
      end
      m_run = 1'b0;
      m_cnt = 0;
      for (int p = 0; p < 2; p++) begin
        e_rd[p] = 64'd0;
        e_bz[p] = 1'b0;
      end
    end else begin
      if (run_pre) begin
        if (wr_en && wr_addr != 5'd31) begin
          m_mem[wr_addr]  = wr_data;
          m_busy[wr_addr] = 1'b0;
        end
        if (claim_en && claim_addr != 5'd31)
          m_busy[claim_addr] = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        a = int'(rd_addr[p*5 +: 5]);
        e_rd[p] = (!run_pre || a == 31) ? 64'd0 : m_mem[a];
        e_bz[p] = run_pre && (a != 31) && m_busy[a];
      end
      if (!m_run) begin
        m_cnt++;
        if (m_cnt == 32) m_run = 1'b1;
      end
    end
    for (int r = 0; r < 32; r++) e_vec[r] = m_busy[r];
    @(posedge clock);
    #1;
    chk({tag, ".ready"},    {63'd0, ready},       {63'd0, m_run});
    chk({tag, ".busy_vec"}, {32'd0, busy_vec},    {32'd0, e_vec});
    chk({tag, ".rd0"},      rd_data[63:0],        e_rd[0]);
    chk({tag, ".rd1"},      rd_data[127:64],      e_rd[1]);
    chk({tag, ".bz0"},      {63'd0, rd_busy[0]},  {63'd0, e_bz[0]});
    chk({tag, ".bz1"},      {63'd0, rd_busy[1]},  {63'd0, e_bz[1]});
  endtask

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    reset      = 1'b1;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    claim_en   = 1'b0;
    claim_addr = '0;

    for (int k = 0; k < 3; k++) tick("reset");
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_busy_vec", {32'd0, busy_vec}, 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 31; k++) tick("clear");
    chk("ready_low_at_31", {63'd0, ready}, 64'd0);
    tick("clear_last");
    chk("ready_high_at_32", {63'd0, ready}, 64'd1);

    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(31 - r), 5'(r)};
      tick("read_all");
      chk("read_all_zero", rd_data[63:0], 64'd0);
    end

    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1122334455667788;
    tick("wr_x5");
    wr_en = 1'b0; rd_addr = {5'd5, 5'd5};
    tick("rd_x5");
    chk("x5_port0", rd_data[63:0],   64'h1122334455667788);
    chk("x5_port1", rd_data[127:64], 64'h1122334455667788);

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h1234;
    tick("wr_x9_old");
    wr_data = 64'hDEAD; rd_addr = {5'd9, 5'd9};
    tick("bypass_x9");
    chk("bypass_x9", rd_data[63:0], 64'hDEAD);

    wr_addr = 5'd31; wr_data = 64'hFFFF; claim_en = 1'b1; claim_addr = 5'd31;
    rd_addr = {5'd31, 5'd31};
    tick("x31_wr_claim");
    wr_en = 1'b0; claim_en = 1'b0;
    tick("x31_read");
    chk("x31_data", rd_data[63:0], 64'd0);
    chk("x31_busy", {62'd0, rd_busy}, 64'd0);
    chk("x31_vec", {63'd0, busy_vec[31]}, 64'd0);

    claim_en = 1'b1; claim_addr = 5'd3;
    tick("claim_x3");
    claim_en = 1'b0;
    tick("idle");
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h33; claim_en = 1'b1; claim_addr = 5'd3;
    tick("x3_wr_and_claim");
    chk("x3_still_busy", {63'd0, busy_vec[3]}, 64'd1);
    wr_en = 1'b0; claim_en = 1'b0; rd_addr = {5'd3, 5'd3};
    tick("x3_rd_busy");
    chk("x3_rd_busy_set", {62'd0, rd_busy}, 64'd3);
    wr_en = 1'b1;
    tick("x3_wr_alone");
    chk("x3_vec_clear", {63'd0, busy_vec[3]}, 64'd0);
    chk("x3_rd_busy_clear", {62'd0, rd_busy}, 64'd0);

    wr_addr = 5'd7; wr_data = 64'h55; rd_addr = {5'd7, 5'd7};
    tick("wr_x7");
    wr_en = 1'b0;
    reset = 1'b1;
    tick("mid_run_reset");
    chk("mid_reset_ready", {63'd0, ready}, 64'd0);
    chk("mid_reset_rd", rd_data[63:0], 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 32; k++) tick("reclear");
    chk("reready", {63'd0, ready}, 64'd1);
    tick("rd_x7_after_reset");
    chk("x7_cleared", rd_data[63:0], 64'd0);

    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 299) == 0);
      wr_en      = $urandom_range(0, 1) == 1;
      wr_addr    = pick_addr();
      wr_data    = {$urandom, $urandom};
      claim_en   = $urandom_range(0, 2) == 0;
      claim_addr = pick_addr();
      rd_addr    = {pick_addr(), pick_addr()};
      tick("random");
    end

    reset = 1'b0; wr_en = 1'b0; claim_en = 1'b0;
    tick("drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
